// File: rtl/snake_head_tracker.sv
// snake_head_tracker: snake head position/direction tracker with IDLE/RUN/DEAD game FSM
module snake_head_tracker #(
  parameter int GRID_W  = 16,
  parameter int GRID_H  = 12,
  parameter int START_X = 8,
  parameter int START_Y = 6
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [1:0] direction_in,
  input  logic       move_tick,
  input  logic       enable,
  input  logic       clear,
  output logic [3:0] head_x,
  output logic [3:0] head_y,
  output logic [1:0] dir_cur,
  output logic       moved,
  output logic       wall_hit,
  output logic [1:0] state_out
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DEAD = 2'b10} state_t;
  localparam logic [1:0] UP = 2'b00, DOWN = 2'b01, LEFT = 2'b10, RIGHT = 2'b11;
  localparam logic [4:0] X_MAX = 5'(GRID_W - 1);
  localparam logic [4:0] Y_MAX = 5'(GRID_H - 1);
  localparam logic [3:0] X0 = 4'(START_X);
  localparam logic [3:0] Y0 = 4'(START_Y);
  logic [1:0] state_q;
  state_t     st, st_n;
  logic [3:0] x_n, y_n;
  logic [1:0] dir_n, dir_res;
  logic       moved_n, wall_n, step, hit;
  logic [4:0] x_try, y_try;
  // Decode the state; the unused encoding falls back to IDLE. Step arithmetic is 5 bits
  // so that 0-1 becomes 31 and is caught by the upper-bound compare instead of wrapping.
  always_comb begin
    st      = (state_q == 2'b11) ? IDLE : state_t'(state_q);
    dir_res = ((direction_in ^ dir_cur) == 2'b01) ? dir_cur : direction_in;
    x_try   = {1'b0, head_x} + ((dir_res == RIGHT) ? 5'd1 : (dir_res == LEFT) ? 5'h1f : 5'd0);
    y_try   = {1'b0, head_y} + ((dir_res == DOWN) ? 5'd1 : (dir_res == UP) ? 5'h1f : 5'd0);
    hit     = (x_try > X_MAX) || (y_try > Y_MAX);
    step    = (st == RUN) && enable && move_tick;
    st_n    = st;
    x_n     = head_x;
    y_n     = head_y;
    dir_n   = dir_cur;
    moved_n = 1'b0;
    wall_n  = wall_hit;
    if (clear) begin
      st_n   = IDLE;
      x_n    = X0;
      y_n    = Y0;
      dir_n  = RIGHT;
      wall_n = 1'b0;
    end else if (st == IDLE) begin
      st_n = enable ? RUN : IDLE;
    end else if (st == RUN && !enable) begin
      st_n = IDLE;
    end else if (step) begin
      dir_n = dir_res;
      if (hit) begin
        st_n   = DEAD;
        wall_n = 1'b1;
      end else begin
        x_n     = x_try[3:0];
        y_n     = y_try[3:0];
        moved_n = 1'b1;
      end
    end
  end
  // Register game state; reset forces the start position immediately.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      head_x   <= X0;
      head_y   <= Y0;
      dir_cur  <= RIGHT;
      moved    <= 1'b0;
      wall_hit <= 1'b0;
    end else begin
      state_q  <= st_n;
      head_x   <= x_n;
      head_y   <= y_n;
      dir_cur  <= dir_n;
      moved    <= moved_n;
      wall_hit <= wall_n;
    end
  end
  assign state_out = state_q;
endmodule

// File: tb/tb_snake_head_tracker.sv
// tb_snake_head_tracker: directed table-driven bench for snake_head_tracker
module tb_snake_head_tracker;
  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic [1:0] direction_in = 2'b11;
  logic       move_tick = 1'b0, enable = 1'b0, clear = 1'b0;
  logic [3:0] head_x, head_y;
  logic [1:0] dir_cur, state_out;
  logic       moved, wall_hit;
  int checks = 0, failures = 0;

  snake_head_tracker dut (
    .clk(clk), .nrst(nrst), .direction_in(direction_in), .move_tick(move_tick),
    .enable(enable), .clear(clear), .head_x(head_x), .head_y(head_y),
    .dir_cur(dir_cur), .moved(moved), .wall_hit(wall_hit), .state_out(state_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       c, e, t;
    logic [1:0] d;
    logic [3:0] x, y;
    logic [1:0] dc;
    logic       m, w;
    logic [1:0] s;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input int x, input int y, input int d,
                         input int m, input int w, input int s);
    chk({name, ".x"}, head_x, x);
    chk({name, ".y"}, head_y, y);
    chk({name, ".dir"}, dir_cur, d);
    chk({name, ".moved"}, moved, m);
    chk({name, ".wall"}, wall_hit, w);
    chk({name, ".state"}, state_out, s);
  endtask

  task automatic cyc(input logic c, input logic e, input logic t, input logic [1:0] d);
    clear = c; enable = e; move_tick = t; direction_in = d;
    @(posedge clk);
    #1;
    clear = 0; move_tick = 0;
  endtask

  vec_t vt[12];
  int pulses;

  initial begin
    // c e t d    x  y  dc m w s
    vt[0]  = '{0,1,0,2'd3,  8, 6, 3, 0, 0, 1};
    vt[1]  = '{0,1,1,2'd3,  9, 6, 3, 1, 0, 1};
    vt[2]  = '{0,1,0,2'd3,  9, 6, 3, 0, 0, 1};
    vt[3]  = '{0,1,1,2'd3, 10, 6, 3, 1, 0, 1};
    vt[4]  = '{0,1,0,2'd3, 10, 6, 3, 0, 0, 1};
    vt[5]  = '{0,1,1,2'd3, 11, 6, 3, 1, 0, 1};
    vt[6]  = '{0,1,1,2'd2, 12, 6, 3, 1, 0, 1};
    vt[7]  = '{0,0,0,2'd0, 12, 6, 3, 0, 0, 0};
    vt[8]  = '{0,1,1,2'd0, 12, 6, 3, 0, 0, 1};
    vt[9]  = '{0,1,1,2'd0, 12, 5, 0, 1, 0, 1};
    vt[10] = '{0,0,1,2'd1, 12, 5, 0, 0, 0, 0};
    vt[11] = '{1,1,1,2'd0,  8, 6, 3, 0, 0, 0};

    #12;
    chk_all("reset", 8, 6, 3, 0, 0, 0);
    @(negedge clk);
    nrst = 1;
    cyc(0, 0, 1, 2'd0);
    chk_all("idle_hold", 8, 6, 3, 0, 0, 0);

    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(vt[i].c, vt[i].e, vt[i].t, vt[i].d);
      chk_all($sformatf("vec%0d", i), vt[i].x, vt[i].y, vt[i].dc, vt[i].m, vt[i].w, vt[i].s);
      if (i < 6) pulses += moved;
    end
    chk("three_pulses", pulses, 3);

    // Left wall at (0,5)
    cyc(0, 1, 0, 2'd3);
    cyc(0, 1, 1, 2'd0);
    for (int i = 0; i < 8; i++) cyc(0, 1, 1, 2'd2);
    chk_all("at_0_5", 0, 5, 2, 1, 0, 1);
    cyc(0, 1, 1, 2'd2);
    chk_all("left_wall", 0, 5, 2, 0, 1, 2);
    cyc(0, 1, 1, 2'd3);
    cyc(0, 0, 1, 2'd1);
    cyc(0, 1, 1, 2'd1);
    chk_all("dead_hold", 0, 5, 2, 0, 1, 2);

    // Bottom wall at (3,11)
    cyc(1, 0, 0, 2'd3);
    chk_all("clear_dead", 8, 6, 3, 0, 0, 0);
    cyc(0, 1, 0, 2'd3);
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, 2'd1);
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, 2'd2);
    chk_all("at_3_11", 3, 11, 2, 1, 0, 1);
    cyc(0, 1, 1, 2'd1);
    chk_all("bottom_wall", 3, 11, 1, 0, 1, 2);

    // Top wall at y=0
    cyc(1, 0, 0, 2'd3);
    cyc(0, 1, 0, 2'd3);
    for (int i = 0; i < 6; i++) cyc(0, 1, 1, 2'd0);
    chk_all("at_8_0", 8, 0, 0, 1, 0, 1);
    cyc(0, 1, 1, 2'd0);
    chk_all("top_wall", 8, 0, 0, 0, 1, 2);

    // Right wall at x=15
    cyc(1, 0, 0, 2'd3);
    cyc(0, 1, 0, 2'd3);
    for (int i = 0; i < 7; i++) cyc(0, 1, 1, 2'd3);
    chk_all("at_15_6", 15, 6, 3, 1, 0, 1);
    cyc(0, 1, 1, 2'd3);
    chk_all("right_wall", 15, 6, 3, 0, 1, 2);

    // Clear priority at (2,2)
    cyc(1, 0, 0, 2'd3);
    cyc(0, 1, 0, 2'd3);
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 2'd0);
    for (int i = 0; i < 6; i++) cyc(0, 1, 1, 2'd2);
    chk_all("at_2_2", 2, 2, 2, 1, 0, 1);
    cyc(1, 1, 1, 2'd2);
    chk_all("clear_prio", 8, 6, 3, 0, 0, 0);

    // Asynchronous reset between edges, with a tick pending
    cyc(0, 1, 0, 2'd3);
    cyc(0, 1, 1, 2'd1);
    chk_all("pre_rst", 8, 7, 1, 1, 0, 1);
    enable = 1; move_tick = 1; direction_in = 2'd2;
    #2;
    nrst = 0;
    #1;
    chk_all("async_rst", 8, 6, 3, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_all("rst_held", 8, 6, 3, 0, 0, 0);
    move_tick = 0; enable = 0;
    @(negedge clk);
    nrst = 1;
    cyc(0, 0, 1, 2'd2);
    chk_all("post_rst_idle", 8, 6, 3, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
